eth_reader: RTL and testbench

ETH_READER -- requirements
Module: eth_reader

---
 rtl/eth_reader.sv | 172 +++++++++++++++++
 tb/tb_eth_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_reader.sv
// eth_reader: copies frames from the rx driver into a byte-addressed RAM ring.
// The producer pointer is published only after every word of a frame is stored.
module eth_reader #(
  parameter int DATA_WIDTH_MSB     = 15,
  parameter int ADDR_WIDTH_MSB     = 15,
  parameter int ETH_MAX_FRAME_SIZE = 256,
  parameter int RING_BYTES         = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH_MSB:0]       reg_ether_READ_FRAME_BASE,
  input  logic [DATA_WIDTH_MSB:0]       reg_ether_READ_FRAME_RD_PTR,
  output logic [DATA_WIDTH_MSB:0]       reg_ether_READ_FRAME_WR_PTR,
  output logic [3:0]                    read_fsm_state,
  output logic [7:0]                    drop_count,
  input  logic [ETH_MAX_FRAME_SIZE-1:0] rx_drv_rd_data,
  input  logic                          rx_drv_rd_valid,
  output logic                          rx_drv_rd_ready,
  output logic [ADDR_WIDTH_MSB:0]       ram_wr_addr,
  output logic [DATA_WIDTH_MSB:0]       ram_wr_data,
  output logic                          ram_wr_valid,
  input  logic                          ram_wr_ready
);

  localparam int DW = DATA_WIDTH_MSB + 1;
  localparam int AW = ADDR_WIDTH_MSB + 1;
  localparam int FS = ETH_MAX_FRAME_SIZE;
  localparam int FB = FS / 8;
  localparam int WB = DW / 8;
  localparam int NW = FB / WB;
  localparam int PW = $clog2(RING_BYTES);
  localparam int IW = $clog2(NW + 1);
  localparam logic [PW-1:0] FB_P   = PW'(FB);
  localparam logic [PW-1:0] WB_P   = PW'(WB);
  localparam logic [PW-1:0] ONE_P  = PW'(1);
  localparam logic [IW-1:0] LAST_P = IW'(NW - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CHECK  = 4'd1,
    WRITE  = 4'd2,
    COMMIT = 4'd3
  } state_t;

  state_t          state_r, state_next_s;
  logic [FS-1:0]   frame_r, frame_next_s, frame_shift_s;
  logic [PW-1:0]   wp_r, wp_next_s, free_s;
  logic [IW-1:0]   widx_r, widx_next_s;
  logic [DW-1:0]   wr_ptr_r, wr_ptr_next_s;
  logic [7:0]      drop_r, drop_next_s;
  logic            ready_r, ready_next_s;
  logic            valid_r, valid_next_s;
  logic [AW-1:0]   addr_r, addr_next_s;
  logic [DW-1:0]   data_r, data_next_s;
  logic            hs_s, acc_s, room_s, last_s;
  logic            unused_rd_ptr_s;

  // Ring offsets wrap inside the ring before the base is added
  function automatic logic [AW-1:0] ring_addr(input logic [DW-1:0] base, input logic [PW-1:0] ofs);
    logic [DW-1:0] sum;
    sum = base + DW'(ofs);
    return AW'(sum);
  endfunction

  assign hs_s            = rx_drv_rd_valid && ready_r;
  assign acc_s           = valid_r && ram_wr_ready;
  assign last_s          = (widx_r == LAST_P);
  assign free_s          = reg_ether_READ_FRAME_RD_PTR[PW-1:0] - wp_r - ONE_P;
  assign room_s          = (free_s >= FB_P);
  assign frame_shift_s   = frame_r << DW;
  assign unused_rd_ptr_s = ^(reg_ether_READ_FRAME_RD_PTR >> PW);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (hs_s) state_next_s = CHECK; else state_next_s = IDLE;
      CHECK:   if (room_s) state_next_s = WRITE; else state_next_s = IDLE;
      WRITE:   if (acc_s && last_s) state_next_s = COMMIT; else state_next_s = WRITE;
      COMMIT:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next values for the frame buffer, pointers and registered outputs
  always_comb begin
    frame_next_s  = frame_r;
    wp_next_s     = wp_r;
    widx_next_s   = widx_r;
    wr_ptr_next_s = wr_ptr_r;
    drop_next_s   = drop_r;
    valid_next_s  = valid_r;
    addr_next_s   = addr_r;
    data_next_s   = data_r;
    ready_next_s  = (state_next_s == IDLE);
    case (state_r)
      IDLE: begin
        if (hs_s) frame_next_s = rx_drv_rd_data; else frame_next_s = frame_r;
      end
      CHECK: begin
        if (room_s) begin
          valid_next_s = 1'b1;
          addr_next_s  = ring_addr(reg_ether_READ_FRAME_BASE, wp_r);
          data_next_s  = frame_r[FS-1 -: DW];
          widx_next_s  = {IW{1'b0}};
        end else begin
          drop_next_s  = (drop_r == 8'hFF) ? drop_r : drop_r + 8'd1;
        end
      end
      WRITE: begin
        if (acc_s) begin
          wp_next_s    = wp_r + WB_P;
          widx_next_s  = widx_r + IW'(1);
          frame_next_s = frame_shift_s;
          if (last_s) begin
            valid_next_s = 1'b0;
          end else begin
            addr_next_s  = ring_addr(reg_ether_READ_FRAME_BASE, wp_r + WB_P);
            data_next_s  = frame_shift_s[FS-1 -: DW];
          end
        end else begin
          valid_next_s = valid_r;
        end
      end
      COMMIT:  wr_ptr_next_s = DW'(wp_r);
      default: wr_ptr_next_s = wr_ptr_r;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_r  <= {FS{1'b0}};
      wp_r     <= {PW{1'b0}};
      widx_r   <= {IW{1'b0}};
      wr_ptr_r <= {DW{1'b0}};
      drop_r   <= 8'd0;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
      addr_r   <= {AW{1'b0}};
      data_r   <= {DW{1'b0}};
    end else begin
      frame_r  <= frame_next_s;
      wp_r     <= wp_next_s;
      widx_r   <= widx_next_s;
      wr_ptr_r <= wr_ptr_next_s;
      drop_r   <= drop_next_s;
      ready_r  <= ready_next_s;
      valid_r  <= valid_next_s;
      addr_r   <= addr_next_s;
      data_r   <= data_next_s;
    end
  end

  assign reg_ether_READ_FRAME_WR_PTR = wr_ptr_r;
  assign read_fsm_state              = state_r;
  assign drop_count                  = drop_r;
  assign rx_drv_rd_ready             = ready_r;
  assign ram_wr_addr                 = addr_r;
  assign ram_wr_data                 = data_r;
  assign ram_wr_valid                = valid_r;

endmodule

// File: tb/tb_eth_reader.sv
// Self-checking bench for eth_reader: directed ring scenarios plus random frames,
// checked against a frame-level ring model and a write scoreboard.
module tb_eth_reader;
  localparam int DW = 16, AW = 16, FS = 256, RING = 128;
  localparam int FB = FS / 8, WB = DW / 8, NW = FB / WB;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0] base = 16'h0100, rd_ptr = 16'h0000, wr_ptr;
  logic [3:0] fsm_state;
  logic [7:0] drop_count;
  logic [FS-1:0] rx_data = {FS{1'b0}};
  logic rx_valid = 1'b0, rx_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic wr_valid, wr_ready = 1'b1;

  int n_cmp = 0, n_bad = 0, acc_cnt = 0, bp_mode = 0;
  int m_wp = 0, m_wrptr = 0, m_drop = 0;
  wr_t exp_q[$];

  logic stall_r = 1'b0, prev_rst_r = 1'b0;
  wr_t held_r;
  logic [DW-1:0] prev_wrptr_r = 16'h0000;
  logic [3:0] prev_state_r = 4'd0;

  always #5 clk = ~clk;

  eth_reader #(.DATA_WIDTH_MSB(DW-1), .ADDR_WIDTH_MSB(AW-1),
               .ETH_MAX_FRAME_SIZE(FS), .RING_BYTES(RING)) dut (
    .clk(clk), .rst(rst),
    .reg_ether_READ_FRAME_BASE(base),
    .reg_ether_READ_FRAME_RD_PTR(rd_ptr),
    .reg_ether_READ_FRAME_WR_PTR(wr_ptr),
    .read_fsm_state(fsm_state), .drop_count(drop_count),
    .rx_drv_rd_data(rx_data), .rx_drv_rd_valid(rx_valid), .rx_drv_rd_ready(rx_ready),
    .ram_wr_addr(wr_addr), .ram_wr_data(wr_data),
    .ram_wr_valid(wr_valid), .ram_wr_ready(wr_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: scoreboard, stall stability and commit-only pointer updates
  always @(negedge clk) begin
    if (rst === 1'b1 && wr_valid === 1'b1) begin
      if (stall_r) begin
        check("stall_addr_stable", 32'(wr_addr), 32'(held_r.a));
        check("stall_data_stable", 32'(wr_data), 32'(held_r.d));
      end
      if (wr_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", 32'(exp_q.size()), 32'd1);
        end else begin
          check("write_addr", 32'(wr_addr), 32'(exp_q[0].a));
          check("write_data", 32'(wr_data), 32'(exp_q[0].d));
          void'(exp_q.pop_front());
        end
        acc_cnt <= acc_cnt + 1;
        stall_r <= 1'b0;
      end else begin
        stall_r <= 1'b1;
        held_r  <= '{a: wr_addr, d: wr_data};
      end
    end else begin
      stall_r <= 1'b0;
    end
    if (rst === 1'b1 && prev_rst_r === 1'b1 && wr_ptr !== prev_wrptr_r)
      check("wr_ptr_commit_only", 32'(prev_state_r), 32'd3);
    prev_rst_r   <= rst;
    prev_wrptr_r <= wr_ptr;
    prev_state_r <= fsm_state;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tic();
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = ~wr_ready;
      default: wr_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wp = 0; m_wrptr = 0; m_drop = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tic();
    model_reset();
    rst = 1'b1;
  endtask

  // Frame-level ring model: returns 1 when the frame fits
  function automatic bit model_frame(input logic [FS-1:0] f);
    int free;
    wr_t e;
    free = (int'(rd_ptr) - m_wp - 1) & (RING - 1);
    if (free >= FB) begin
      for (int k = 0; k < NW; k++) begin
        e.a = AW'(int'(base) + ((m_wp + k * WB) % RING));
        e.d = f[FS-1-k*DW -: DW];
        exp_q.push_back(e);
      end
      m_wp = (m_wp + FB) % RING;
      m_wrptr = m_wp;
      return 1'b1;
    end
    m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    return 1'b0;
  endfunction

  task automatic handshake(input logic [FS-1:0] f, output bit fits);
    int n;
    smp();
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin tic(); smp(); n++; end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_data = f;
    rx_valid = 1'b1;
    fits = model_frame(f);
    tic();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [FS-1:0] f);
    int n;
    bit fits;
    handshake(f, fits);
    smp();
    n = 0;
    while (rx_ready !== 1'b1 && n < 400) begin tic(); smp(); n++; end
    check("frame_done", 32'(rx_ready), 32'd1);
    if (bp_mode == 0) check("latency", 32'(n), fits ? 32'(NW + 2) : 32'd1);
    check("wr_ptr", 32'(wr_ptr), 32'(m_wrptr));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [FS-1:0] rand_frame();
    logic [FS-1:0] f;
    for (int i = 0; i < FS / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  initial begin
    logic [FS-1:0] f;
    int a0, n;
    bit fits;

    // Reset values and ready release
    do_reset(2);
    rst = 1'b0;
    smp();
    check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    rst = 1'b1;
    tic();
    smp();
    check("ready_after_release", 32'(rx_ready), 32'd1);

    // Single frame, words A000+k MSB first
    base = 16'h0100; rd_ptr = 16'h0000; bp_mode = 0;
    for (int k = 0; k < NW; k++) f[FS-1-k*DW -: DW] = 16'hA000 + 16'(k);
    send_frame(f);
    check("single_wr_ptr", 32'(wr_ptr), 32'h20);

    // Alternating backpressure
    do_reset(2);
    bp_mode = 1;
    send_frame(rand_frame());
    check("bp_wr_ptr", 32'(wr_ptr), 32'h20);

    // Full ring: fourth frame dropped
    do_reset(2);
    bp_mode = 2;
    for (int i = 0; i < 4; i++) send_frame(rand_frame());
    check("full_wr_ptr", 32'(wr_ptr), 32'h60);
    check("full_drop", 32'(drop_count), 32'd1);

    // Wrap around the ring end
    rd_ptr = 16'h0040; bp_mode = 0;
    send_frame(rand_frame());
    check("wrap_wr_ptr0", 32'(wr_ptr), 32'h00);
    send_frame(rand_frame());
    check("wrap_wr_ptr1", 32'(wr_ptr), 32'h20);

    // Random base, consumer pointer and backpressure
    do_reset(2);
    for (int i = 0; i < 30; i++) begin
      base = 16'($urandom);
      rd_ptr = 16'($urandom);
      bp_mode = int'($urandom_range(0, 2));
      send_frame(rand_frame());
    end

    // Drop counter saturation with a permanently full ring
    bp_mode = 0;
    rd_ptr = 16'((m_wp + 1) % RING);
    for (int i = 0; i < 260; i++) send_frame(rand_frame());
    check("drop_saturated", 32'(drop_count), 32'd255);

    // Reset after five accepted words
    do_reset(2);
    base = 16'h0300; rd_ptr = 16'h0000; bp_mode = 0;
    handshake(rand_frame(), fits);
    a0 = acc_cnt;
    smp();
    n = 0;
    while (acc_cnt - a0 < 5 && n < 50) begin tic(); smp(); n++; end
    check("five_words", 32'(acc_cnt - a0), 32'd5);
    tic();
    rst = 1'b0;
    tic();
    smp();
    model_reset();
    check("midrst_wr_valid", 32'(wr_valid), 32'd0);
    check("midrst_wr_ptr", 32'(wr_ptr), 32'd0);
    rst = 1'b1;
    send_frame(rand_frame());
    check("after_midrst_wr_ptr", 32'(wr_ptr), 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
